// File: rtl/calc_core_seq_pkg.sv
// Shared types and constants for the calculator core.
// Divider support is selected by the CALC_DIV_EN macro in the core and divider files.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        COMPUTE,
        DIVIDE,
        SHOW
    } state_t;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        MUL,
        DIV
    } op_t;

    localparam logic [1:0] PH_ENTER_A = 2'd0;
    localparam logic [1:0] PH_ENTER_B = 2'd1;
    localparam logic [1:0] PH_SHOW    = 2'd2;
    localparam logic [1:0] PH_BUSY    = 2'd3;

    // Returned at 32 bits; callers cast down to their operand width.
    function automatic logic [31:0] pow10(input int i);
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < i; k++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_core_seq_if.sv
// Button/slider inputs and display/status outputs of the calculator core.
interface calc_core_seq_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic              btn_ent;
    logic              btn_clr;
    logic [DIGITS-1:0] digit_inc;
    logic [1:0]        op_sel;
    logic [WIDTH-1:0]  display_value;
    logic [1:0]        phase;
    logic              neg;
    logic              ovf;
    logic              err;
    logic              busy;

    modport master (
        output btn_ent, btn_clr, digit_inc, op_sel,
        input  display_value, phase, neg, ovf, err, busy
    );

    modport slave (
        input  btn_ent, btn_clr, digit_inc, op_sel,
        output display_value, phase, neg, ovf, err, busy
    );
endinterface

// File: rtl/calc_core_seq_divider.sv
// WIDTH-cycle restoring divider, one quotient bit per cycle, MSB first.
// Only compiled into the core when CALC_DIV_EN is defined.
module calc_divider #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;

    // Negative trial difference shows up as a set MSB; restore by keeping rem_sh.
    always_comb begin
        rem_sh = {rem, q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        ge     = ~diff[WIDTH];
    end

    // done marks the cycle whose step yields the final quotient bit.
    assign busy     = (cnt != '0);
    assign done     = (cnt == CNT_W'(1));
    assign quotient = {q[WIDTH-2:0], ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
            q   <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= '0;
            q   <= dividend;
            dvs <= divisor;
            cnt <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], ge};
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/calc_core_seq.sv
// Calculator core: digit-by-digit operand entry, add/sub/mul in one cycle, optional divide.
// Define CALC_DIV_EN to build in the restoring divider and the DIVIDE state.
//
// state   | meaning
// ENTER_A | entering operand A, display A
// ENTER_B | entering operand B, display B
// COMPUTE | one-cycle arithmetic or divider launch, display holds B
// DIVIDE  | divider running, display holds B
// SHOW    | result and flags displayed
module calc_core_seq
    import calc_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int DIGITS    = 4,
    parameter int MAX_VALUE = 10**DIGITS - 1
) (
    input  logic            clk,
    input  logic            reset,
    calc_core_seq_if.slave  bus
);
    localparam logic [WIDTH-1:0]   MAX_W = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH:0]     MAX_E = (WIDTH+1)'(MAX_VALUE);
    localparam logic [2*WIDTH-1:0] MAX_L = (2*WIDTH)'(MAX_VALUE);

    state_t           state, state_n;
    op_t              op, op_n;
    logic [WIDTH-1:0] a, b, a_n, b_n;

    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   cur_sum;
    logic [WIDTH-1:0] cur_inc;

    logic [2*WIDTH-1:0] a_l, b_l, mag;
    logic               mag_neg;

    logic [WIDTH-1:0] disp_n;
    logic [1:0]       phase_n;
    logic             neg_n, ovf_n, err_n, busy_n;

`ifdef CALC_DIV_EN
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;

    calc_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (a),
        .divisor  (b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );
`endif

    // All set digit pulses are summed first, then the operand wraps once.
    always_comb begin
        inc_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.digit_inc[i]) inc_sum = inc_sum + (WIDTH+1)'(pow10(i));
        end
        cur_sum = {1'b0, (state == ENTER_B) ? b : a} + inc_sum;
        if (cur_sum > MAX_E) cur_sum = cur_sum - (MAX_E + (WIDTH+1)'(1));
        cur_inc = cur_sum[WIDTH-1:0];
    end

    always_comb begin
        a_l     = (2*WIDTH)'(a);
        b_l     = (2*WIDTH)'(b);
        mag     = '0;
        mag_neg = 1'b0;
        case (op)
            ADD: mag = a_l + b_l;
            SUB: begin
                mag_neg = (b_l > a_l);
                mag     = mag_neg ? (b_l - a_l) : (a_l - b_l);
            end
            MUL: mag = a_l * b_l;
            default: mag = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ENTER_A;
            op                <= ADD;
            a                 <= '0;
            b                 <= '0;
            bus.display_value <= '0;
            bus.phase         <= PH_ENTER_A;
            bus.neg           <= 1'b0;
            bus.ovf           <= 1'b0;
            bus.err           <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            state             <= state_n;
            op                <= op_n;
            a                 <= a_n;
            b                 <= b_n;
            bus.display_value <= disp_n;
            bus.phase         <= phase_n;
            bus.neg           <= neg_n;
            bus.ovf           <= ovf_n;
            bus.err           <= err_n;
            bus.busy          <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        a_n     = a;
        b_n     = b;
`ifdef CALC_DIV_EN
        div_start = 1'b0;
`endif
        case (state)
            ENTER_A: begin
                if (bus.btn_clr) begin
                    a_n = '0;
                end else begin
                    a_n = cur_inc;
                    if (bus.btn_ent) state_n = ENTER_B;
                end
            end
            ENTER_B: begin
                if (bus.btn_clr) begin
                    b_n = '0;
                end else begin
                    b_n = cur_inc;
                    if (bus.btn_ent) begin
                        state_n = COMPUTE;
                        op_n    = op_t'(bus.op_sel);
                    end
                end
            end
            COMPUTE: begin
                state_n = SHOW;
`ifdef CALC_DIV_EN
                if (op == DIV && b != '0) begin
                    state_n   = DIVIDE;
                    div_start = 1'b1;
                end
`endif
            end
`ifdef CALC_DIV_EN
            // The !div_busy term only guards against a stuck divider.
            DIVIDE: if (div_done || !div_busy) state_n = SHOW;
`endif
            SHOW: begin
                if (bus.btn_clr) begin
                    a_n     = '0;
                    b_n     = '0;
                    state_n = ENTER_A;
                end else if (bus.btn_ent) begin
                    state_n = ENTER_A;
                end
            end
            default: state_n = ENTER_A;
        endcase
    end

    always_comb begin
        disp_n = '0;
        neg_n  = 1'b0;
        ovf_n  = 1'b0;
        err_n  = 1'b0;
        busy_n = (state_n == COMPUTE) || (state_n == DIVIDE);
        case (state_n)
            ENTER_A: phase_n = PH_ENTER_A;
            ENTER_B: phase_n = PH_ENTER_B;
            SHOW:    phase_n = PH_SHOW;
            default: phase_n = PH_BUSY;
        endcase
        case (state_n)
            ENTER_A:          disp_n = a_n;
            ENTER_B:          disp_n = b_n;
            COMPUTE, DIVIDE:  disp_n = b_n;
            SHOW: begin
                if (state == SHOW) begin
                    disp_n = bus.display_value;
                    neg_n  = bus.neg;
                    ovf_n  = bus.ovf;
                    err_n  = bus.err;
                end else if (state == COMPUTE) begin
                    if (op == DIV) begin
                        // Reached only on divide by zero or without a divider.
                        err_n = 1'b1;
                    end else begin
                        neg_n  = mag_neg;
                        ovf_n  = (mag > MAX_L);
                        disp_n = (mag > MAX_L) ? MAX_W : mag[WIDTH-1:0];
                    end
                end else begin
`ifdef CALC_DIV_EN
                    disp_n = div_quotient;
`endif
                end
            end
            default: disp_n = '0;
        endcase
    end
endmodule

// File: tb/tb_calc_core_seq.sv
// Directed bench for calc_core_seq; divide-path checks follow CALC_DIV_EN.
module tb_calc_core_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   busy_cnt;

    always #5 clk = ~clk;

    calc_core_seq_if #(.WIDTH(14), .DIGITS(4)) bus ();

    calc_core_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_digits(input logic [3:0] mask);
        bus.digit_inc = mask;
        tick();
        bus.digit_inc = '0;
    endtask

    task automatic ent();
        bus.btn_ent = 1'b1;
        tick();
        bus.btn_ent = 1'b0;
    endtask

    task automatic clr();
        bus.btn_clr = 1'b1;
        tick();
        bus.btn_clr = 1'b0;
    endtask

    // Builds v from zero: round r pulses every digit whose value is at least r.
    task automatic enter(input int v);
        logic [3:0] mask;
        int p;
        for (int r = 1; r <= 9; r++) begin
            mask = '0;
            p = 1;
            for (int i = 0; i < 4; i++) begin
                if ((v / p) % 10 >= r) mask[i] = 1'b1;
                p = p * 10;
            end
            if (mask != '0) pulse_digits(mask);
        end
    endtask

    initial begin
        bus.btn_ent   = 1'b0;
        bus.btn_clr   = 1'b0;
        bus.digit_inc = '0;
        bus.op_sel    = 2'b00;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_disp",  bus.display_value, 0);
        check("rst_phase", bus.phase, 0);
        check("rst_neg",   bus.neg, 0);
        check("rst_ovf",   bus.ovf, 0);
        check("rst_err",   bus.err, 0);
        check("rst_busy",  bus.busy, 0);

        pulse_digits(4'b0001);
        check("inc_latency", bus.display_value, 1);
        pulse_digits(4'b0001);
        pulse_digits(4'b0001);
        pulse_digits(4'b0100);
        check("entry_103", bus.display_value, 103);
        check("entry_phase", bus.phase, 0);

        clr();
        check("clr_a", bus.display_value, 0);
        enter(9990);
        check("a_9990", bus.display_value, 9990);
        pulse_digits(4'b0010);
        check("a_wrap", bus.display_value, 0);
        ent();
        check("enter_b_phase", bus.phase, 1);
        enter(5);
        bus.op_sel = 2'b00;
        ent();
        check("add_t1_phase", bus.phase, 3);
        check("add_t1_busy", bus.busy, 1);
        check("add_t1_disp_b", bus.display_value, 5);
        tick();
        check("add_t2_phase", bus.phase, 2);
        check("add_result", bus.display_value, 5);
        check("add_flags", {bus.neg, bus.ovf, bus.err, bus.busy}, 0);

        ent();
        check("show_ent_phase", bus.phase, 0);
        check("show_ent_a", bus.display_value, 0);
        enter(12);
        ent();
        clr();
        enter(30);
        bus.op_sel = 2'b01;
        ent();
        tick();
        check("sub_result", bus.display_value, 18);
        check("sub_neg", bus.neg, 1);
        ent();
        check("sub_exit_phase", bus.phase, 0);
        check("sub_exit_a", bus.display_value, 12);
        check("sub_exit_neg", bus.neg, 0);

        clr();
        enter(200);
        ent();
        clr();
        enter(50);
        bus.op_sel = 2'b10;
        ent();
        tick();
        check("mul_clamp", bus.display_value, 9999);
        check("mul_ovf", bus.ovf, 1);
        clr();
        check("show_clr_phase", bus.phase, 0);
        check("show_clr_disp", bus.display_value, 0);
        check("show_clr_ovf", bus.ovf, 0);

        enter(1000);
        ent();
        check("b_zeroed", bus.display_value, 0);
        enter(7);
        bus.op_sel = 2'b11;
        ent();
`ifdef CALC_DIV_EN
        busy_cnt = 0;
        while (bus.busy && busy_cnt < 100) begin
            busy_cnt++;
            tick();
        end
        check("div_busy_cycles", busy_cnt, 15);
        check("div_quotient", bus.display_value, 142);
        check("div_phase", bus.phase, 2);
        check("div_err", bus.err, 0);
        ent();
        check("div_exit_a", bus.display_value, 1000);
        ent();
        clr();
        bus.op_sel = 2'b11;
        ent();
        tick();
        check("div0_phase", bus.phase, 2);
        check("div0_err", bus.err, 1);
        check("div0_disp", bus.display_value, 0);
`else
        check("nodiv_busy", bus.busy, 1);
        tick();
        check("nodiv_phase", bus.phase, 2);
        check("nodiv_err", bus.err, 1);
        check("nodiv_disp", bus.display_value, 0);
`endif

        ent();
        check("err_cleared", bus.err, 0);
        check("exit_a_1000", bus.display_value, 1000);
        ent();
        clr();
        enter(44);
        check("b_44", bus.display_value, 44);
        bus.btn_clr = 1'b1;
        bus.btn_ent = 1'b1;
        tick();
        bus.btn_clr = 1'b0;
        bus.btn_ent = 1'b0;
        check("clr_ent_disp", bus.display_value, 0);
        check("clr_ent_phase", bus.phase, 1);

        enter(7);
        bus.op_sel = 2'b11;
        ent();
`ifdef CALC_DIV_EN
        tick();
        tick();
        tick();
`endif
        check("pre_abort_phase", bus.phase, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_phase", bus.phase, 0);
        check("abort_disp", bus.display_value, 0);
        check("abort_flags", {bus.neg, bus.ovf, bus.err, bus.busy}, 0);
        tick();
        check("abort_settled", bus.phase, 0);

        enter(3);
        ent();
        bus.op_sel    = 2'b00;
        bus.digit_inc = 4'b0010;
        bus.btn_ent   = 1'b1;
        tick();
        check("inc_ent_disp_b", bus.display_value, 10);
        check("inc_ent_phase", bus.phase, 3);
        // Left asserted through COMPUTE; must be ignored while busy.
        bus.op_sel = 2'b10;
        tick();
        bus.digit_inc = '0;
        bus.btn_ent   = 1'b0;
        check("inc_ent_sum", bus.display_value, 13);
        check("busy_ignore_phase", bus.phase, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
